// File: rtl/sram_stream_reader.sv
// Streams 16-bit words out of an asynchronous SRAM over a programmed address window,
// buffering them in a small FIFO behind a valid/ready interface. Read-only toward the SRAM.
module sram_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20
) (
    input  logic              avm_clk,
    input  logic              avm_rst_n,
    input  logic              i_init_done,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic [15:0]       o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addr,
    inout  wire  [15:0]       io_data,
    output logic              o_we_n,
    output logic              o_ce_n,
    output logic              o_oe_n,
    output logic              o_lb_n,
    output logic              o_ub_n
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_startAddr;
    logic [ADDR_W-1:0]   r_endAddr;
    logic [ADDR_W-1:0]   r_curAddr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pending;
    logic                r_done;
    logic [15:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_reject;
    logic                w_abort;
    logic                w_room;
    logic                w_issue;
    logic                w_isLast;
    logic                w_push;
    logic                w_pop;
    logic                w_drainDone;
    logic [ADDR_W-1:0]   w_issueAddr;
    logic [ADDR_W-1:0]   w_issueEnd;
    logic [ADDR_W-1:0]   w_wrapAddr;

    // The accepting start edge already issues the first read, so the window registers are bypassed there.
    always_comb begin
        w_accept    = (r_state == S_IDLE) && i_start && i_init_done && (i_start_addr <= i_end_addr);
        w_reject    = (r_state == S_IDLE) && i_start && i_init_done && (i_start_addr > i_end_addr);
        w_abort     = (r_state != S_IDLE) && (i_stop || !i_init_done);
        w_room      = ({1'b0, r_count} + SUM_W'(r_pending)) < SUM_W'(FIFO_DEPTH);
        w_issue     = !w_abort && !i_pause && (w_accept || ((r_state == S_RUN) && w_room));
        w_issueAddr = w_accept ? i_start_addr : r_curAddr;
        w_issueEnd  = w_accept ? i_end_addr   : r_endAddr;
        w_wrapAddr  = w_accept ? i_start_addr : r_startAddr;
        w_isLast    = (w_issueAddr == w_issueEnd);
        w_push      = r_pending && !w_abort;
        w_pop       = (r_count != '0) && i_ready;
    end

    always_comb begin
        w_nextState = r_state;
        w_drainDone = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = (w_issue && w_isLast && !i_loop) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_nextState = S_IDLE;
                end else if (w_issue && w_isLast && !i_loop) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_abort) begin
                    w_nextState = S_IDLE;
                end else if (!r_pending && (r_count == '0)) begin
                    w_nextState = S_IDLE;
                    w_drainDone = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_startAddr <= '0;
            r_endAddr   <= '0;
            r_curAddr   <= '0;
            r_addr      <= '0;
            r_pending   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pending <= w_issue;
            r_done    <= w_reject || w_drainDone;
            if (w_accept) begin
                r_startAddr <= i_start_addr;
                r_endAddr   <= i_end_addr;
            end
            // Equality against the end address lets a window ending at the top of memory wrap cleanly.
            if (w_issue) begin
                r_addr    <= w_issueAddr;
                r_curAddr <= w_isLast ? w_wrapAddr : (w_issueAddr + ADDR_W'(1));
            end else if (w_accept) begin
                r_curAddr <= i_start_addr;
            end
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (w_abort) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // The SRAM word for the address registered last edge is captured straight off the bus.
    always_ff @(posedge avm_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= io_data;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rdPtr] : 16'h0000;
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = r_done;
    assign o_addr  = r_addr;
    assign o_we_n  = 1'b1;
    assign o_ce_n  = 1'b0;
    assign o_oe_n  = 1'b0;
    assign o_lb_n  = 1'b0;
    assign o_ub_n  = 1'b0;

endmodule
